vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates VGA raster timing (h_cont/v_cont counters, HSYNC/VSYNC, BLANK) for the camera display path.
- Counters feed the Nios pixel-processing system's h_cont/v_cont inputs.
- Accepts the processed 8-bit R/G/B returned by that system and registers it, aligned to sync/blank, toward the DAC.
- Sits directly downstream of, and provides coordinates to, the Nios colour-processing stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, HSYNC pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CNT_W, 16, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk_clk  in  1  system clock, 50 MHz
- reset_reset_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel clock enable; 1 of every 2 cycles for 25 MHz pixel rate
- red_in  in  8  processed red from the Nios stage
- green_in  in  8  processed green
- blue_in  in  8  processed blue
- h_cont  out  CNT_W  current horizontal position, 0..H_TOTAL-1
- v_cont  out  CNT_W  current line, 0..V_TOTAL-1
- pixel_req  out  1  high while (h_cont, v_cont) is inside the active area
- frame_start  out  1  one-cycle pulse at the start of each frame
- vga_hs  out  1  HSYNC, active low
- vga_vs  out  1  VSYNC, active low
- vga_blank_n  out  1  low outside the active area
- vga_sync_n  out  1  tied 0 (no sync-on-green)
- vga_r  out  8  registered red to DAC
- vga_g  out  8  registered green to DAC
- vga_b  out  8  registered blue to DAC

Behaviour:
- Reset is asynchronous and active-low. Reset values:
  - h_cont=0, v_cont=0
  - vga_hs=1, vga_vs=1, vga_blank_n=0
  - vga_r/g/b=0
  - frame_start=0
  - pixel_req=1, since it is combinational and (0,0) is active.
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- Region order per axis: active [0, ACTIVE-1], front porch, sync, back porch.
- Counters: all state advances only on clk_clk edges with pix_en=1; pix_en=0 holds every register.
  - h_cont increments by 1 and wraps from H_TOTAL-1 to 0.
  - v_cont increments only on that h wrap, and wraps from V_TOTAL-1 to 0 when both wrap together.
- pixel_req = (h_cont < H_ACTIVE) && (v_cont < V_ACTIVE). Combinational from the counter registers.
- The Nios stage returns red_in/green_in/blue_in for the current (h_cont, v_cont) in the same cycle.
- Output register stage, updated on pix_en:
  - vga_hs = ~(h_cont in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1])
  - vga_vs = ~(v_cont in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1])
  - vga_blank_n = pixel_req
  - vga_r/g/b = pixel_req ? *_in : 0
- Latency: DAC outputs lag the counters by exactly one pixel; sync, blank and RGB stay mutually aligned.
- frame_start: registered, 1 for exactly one clk_clk cycle in the pix_en cycle where the counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0). Not asserted on reset exit.
- VSYNC edges coincide with the h wrap, i.e. are aligned to line start.
- Reset mid-frame:
  - Outputs return to reset values immediately, with no clock needed.
  - On release, the scan restarts at (0,0).
  - No frame_start pulse for the partial frame.
- Counter decode uses CNT_W-wide unsigned compares. No counter may ever exceed TOTAL-1.

Test Plan:
1. Reset then free run, pix_en toggling 1/0 -> h_cont counts 0..799 and wraps. v_cont increments on each wrap: 524 -> 0 after 420000 enabled cycles. frame_start pulses once per 420000 enabled cycles.
2. Line timing -> vga_hs low exactly for registered h_cont 656..751 (96 pixels). vga_blank_n high for 640 pixels per active line and 0 for lines 480..524.
3. Frame timing -> vga_vs low only while v_cont is 490..491 (2 lines = 1600 enabled cycles). Falling edge occurs one pixel after h_cont wraps to 0 on v_cont=490.
4. Drive red_in=h_cont[7:0], green_in=v_cont[7:0], blue_in=8'hA5 -> vga_r at the pixel after (h=10,v=20) equals 10, vga_g=20, vga_b=A5. Outputs are 0 at h=640..799 regardless of inputs.
5. pix_en held 0 for 37 cycles mid-line -> all outputs frozen. Resumes from the same h_cont value with no skipped count.
6. Assert reset_reset_n=0 asynchronously at (h=300, v=200) -> outputs take reset values without a clock edge. After release, first enabled count is (1,0). No frame_start until the full 420000-cycle frame completes.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle between the raster timing generator, the Nios colour stage and the DAC.
interface vga_timing_gen_if #(
  parameter int CNT_W = 16
);
  logic             pix_en;
  logic [7:0]       red_in;
  logic [7:0]       green_in;
  logic [7:0]       blue_in;
  logic [CNT_W-1:0] h_cont;
  logic [CNT_W-1:0] v_cont;
  logic             pixel_req;
  logic             frame_start;
  logic             vga_hs;
  logic             vga_vs;
  logic             vga_blank_n;
  logic             vga_sync_n;
  logic [7:0]       vga_r;
  logic [7:0]       vga_g;
  logic [7:0]       vga_b;

  modport master (
    input  pix_en, red_in, green_in, blue_in,
    output h_cont, v_cont, pixel_req, frame_start,
           vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b
  );

  modport slave (
    output pix_en, red_in, green_in, blue_in,
    input  h_cont, v_cont, pixel_req, frame_start,
           vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster counters plus a one-pixel output register stage that keeps sync, blank
// and the returned colour aligned toward the DAC.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int CNT_W    = 16
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START  = H_ACTIVE + H_FRONT;
  localparam int HS_END    = H_ACTIVE + H_FRONT + H_SYNC - 1;
  localparam int VS_START  = V_ACTIVE + V_FRONT;
  localparam int VS_END    = V_ACTIVE + V_FRONT + V_SYNC - 1;
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             h_last, v_last, pix_req;
  logic             hs_q, hs_d, vs_q, vs_d, blank_q, fs_q, fs_d;

  logic [NUM_LANES-1:0][VEC_W-1:0] rgb_in, rgb_q, rgb_d;

  always_comb begin
    h_last  = (h_q == CNT_W'(H_TOTAL - 1));
    v_last  = (v_q == CNT_W'(V_TOTAL - 1));
    h_d     = h_last ? '0 : h_q + CNT_W'(1);
    v_d     = v_q;
    if (h_last) v_d = v_last ? '0 : v_q + CNT_W'(1);
    pix_req = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
    hs_d    = ~((h_q >= CNT_W'(HS_START)) && (h_q <= CNT_W'(HS_END)));
    vs_d    = ~((v_q >= CNT_W'(VS_START)) && (v_q <= CNT_W'(VS_END)));
    // Pulse lives in the single clk cycle following the enabled wrap edge.
    fs_d    = bus.pix_en & h_last & v_last;
  end

  assign rgb_in = {bus.blue_in, bus.green_in, bus.red_in};

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++)
      rgb_d[i] = pix_req ? rgb_in[i] : '0;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      fs_q <= fs_d;
      if (bus.pix_en) begin
        h_q     <= h_d;
        v_q     <= v_d;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        blank_q <= pix_req;
        rgb_q   <= rgb_d;
      end
    end
  end

  assign bus.h_cont      = h_q;
  assign bus.v_cont      = v_q;
  assign bus.pixel_req   = pix_req;
  assign bus.frame_start = fs_q;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank_n = blank_q;
  assign bus.vga_sync_n  = 1'b0;
  assign bus.vga_r       = rgb_q[0];
  assign bus.vga_g       = rgb_q[1];
  assign bus.vga_b       = rgb_q[2];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen on a shrunken 30x15 raster (450 pixels per frame).
module tb_vga_timing_gen;
  localparam int HA = 16, HF = 4, HS = 6, HB = 4;   // H total 30, hsync at 20..25
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;   // V total 15, vsync at 10..11

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        preq;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } obs_t;

  logic clk_clk = 1'b0;
  logic reset_reset_n;
  logic pix_en;
  logic [7:0] bval;

  int checks = 0, errors = 0;
  int hs_cnt = 0, vs_cnt = 0, bl_cnt = 0, fs_cnt = 0;
  bit mon_on = 1'b0;
  obs_t exp_q[$];

  int   mh, mv;
  logic m_fs, m_hs, m_vs, m_bl;
  logic [7:0] m_r, m_g, m_b;

  always #5 clk_clk = ~clk_clk;

  vga_timing_gen_if #(.CNT_W(16)) bus ();

  assign bus.pix_en   = pix_en;
  assign bus.red_in   = bus.h_cont[7:0];
  assign bus.green_in = bus.v_cont[7:0];
  assign bus.blue_in  = bval;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CNT_W(16)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .bus          (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic in_act(input int h, input int v);
    return (h < 16) && (v < 8);
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; m_fs = 0; m_hs = 1; m_vs = 1; m_bl = 0;
    m_r = 0; m_g = 0; m_b = 0;
  endtask

  // One clock: drive pix_en at negedge, predict the post-edge view, wait past the edge.
  task automatic tick(input logic en);
    obs_t e;
    @(negedge clk_clk);
    pix_en = en;
    if (mon_on) begin
      if (en) begin
        m_bl = in_act(mh, mv);
        m_hs = !(mh >= 20 && mh <= 25);
        m_vs = !(mv >= 10 && mv <= 11);
        m_r  = m_bl ? 8'(mh) : 8'h00;
        m_g  = m_bl ? 8'(mv) : 8'h00;
        m_b  = m_bl ? bval   : 8'h00;
        m_fs = (mh == 29) && (mv == 14);
        if (mh == 29) begin
          mh = 0;
          mv = (mv == 14) ? 0 : mv + 1;
        end else mh = mh + 1;
      end else m_fs = 0;
      e.h = 16'(mh); e.v = 16'(mv); e.preq = in_act(mh, mv); e.fs = m_fs;
      e.hs = m_hs; e.vs = m_vs; e.bl = m_bl; e.r = m_r; e.g = m_g; e.b = m_b;
      exp_q.push_back(e);
    end
    @(posedge clk_clk);
    #2;
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v) && n < 2000) begin
      tick(1); tick(0); n++;
    end
    chk("run_to_bound", 32'(n < 2000), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_h"}, 32'(bus.h_cont), 0);
    chk({tag, "_v"}, 32'(bus.v_cont), 0);
    chk({tag, "_hs"}, 32'(bus.vga_hs), 1);
    chk({tag, "_vs"}, 32'(bus.vga_vs), 1);
    chk({tag, "_blank"}, 32'(bus.vga_blank_n), 0);
    chk({tag, "_rgb"}, {8'h0, bus.vga_r, bus.vga_g, bus.vga_b}, 0);
    chk({tag, "_fs"}, 32'(bus.frame_start), 0);
    chk({tag, "_preq"}, 32'(bus.pixel_req), 1);
  endtask

  // Monitor: every clock, compare the DUT view against the oldest prediction.
  obs_t a, e_m;
  logic en_s;
  always @(posedge clk_clk) begin
    en_s = pix_en;
    #1;
    if (mon_on && exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      a.h = bus.h_cont; a.v = bus.v_cont; a.preq = bus.pixel_req; a.fs = bus.frame_start;
      a.hs = bus.vga_hs; a.vs = bus.vga_vs; a.bl = bus.vga_blank_n;
      a.r = bus.vga_r; a.g = bus.vga_g; a.b = bus.vga_b;
      checks++;
      if (a !== e_m) begin
        errors++;
        $display("FAIL scoreboard t=%0t got %h expected %h", $time, a, e_m);
      end
      if (en_s && !bus.vga_hs) hs_cnt++;
      if (en_s && !bus.vga_vs) vs_cnt++;
      if (en_s && bus.vga_blank_n) bl_cnt++;
      if (bus.frame_start) fs_cnt++;
    end
  end

  initial begin
    reset_reset_n = 1'b0;
    pix_en = 1'b0;
    bval = 8'hA5;
    model_reset();
    repeat (3) @(posedge clk_clk);
    #1;
    chk_reset_vals("por");
    chk("sync_n", 32'(bus.vga_sync_n), 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    mon_on = 1'b1;

    // First frame with directed spot checks along the way.
    tick(1); tick(0);
    chk("first_h", 32'(bus.h_cont), 1);
    run_to(10, 5); tick(1);
    chk("act_r", 32'(bus.vga_r), 10);
    chk("act_g", 32'(bus.vga_g), 5);
    chk("act_b", 32'(bus.vga_b), 32'hA5);
    chk("act_blank", 32'(bus.vga_blank_n), 1);
    run_to(17, 5); tick(1);
    chk("porch_rgb", {8'h0, bus.vga_r, bus.vga_g, bus.vga_b}, 0);
    chk("porch_blank", 32'(bus.vga_blank_n), 0);
    run_to(29, 9); tick(1);
    chk("vwrap_h", 32'(bus.h_cont), 0);
    chk("vwrap_v", 32'(bus.v_cont), 10);
    chk("vs_before_edge", 32'(bus.vga_vs), 1);
    tick(0); tick(1);
    chk("vs_fall_h", 32'(bus.h_cont), 1);
    chk("vs_fall", 32'(bus.vga_vs), 0);
    run_to(0, 0);
    chk("frame_hs_low", hs_cnt, 90);
    chk("frame_vs_low", vs_cnt, 60);
    chk("frame_blank_hi", bl_cnt, 128);
    chk("frame_fs", fs_cnt, 1);

    // Stall mid-line for 37 clocks.
    bval = 8'h3C;
    run_to(12, 2);
    repeat (37) tick(0);
    chk("stall_h", 32'(bus.h_cont), 12);
    chk("stall_v", 32'(bus.v_cont), 2);
    chk("stall_r", 32'(bus.vga_r), 11);
    chk("stall_b", 32'(bus.vga_b), 32'h3C);
    tick(1);
    chk("resume_h", 32'(bus.h_cont), 13);
    chk("resume_r", 32'(bus.vga_r), 12);

    // Asynchronous reset in the middle of an active line.
    run_to(7, 3);
    chk("pre_rst_r", 32'(bus.vga_r), 6);
    @(negedge clk_clk);
    mon_on = 1'b0;
    pix_en = 1'b1;
    #2 reset_reset_n = 1'b0;
    #1 chk_reset_vals("async");
    repeat (3) @(posedge clk_clk);
    #1 chk("held_h", 32'(bus.h_cont), 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    pix_en = 1'b0;
    model_reset();
    mon_on = 1'b1;
    tick(1);
    chk("post_rst_h", 32'(bus.h_cont), 1);
    chk("post_rst_v", 32'(bus.v_cont), 0);
    for (int i = 0; i < 448; i++) begin
      tick(0); tick(1);
    end
    chk("no_early_fs", fs_cnt, 1);
    tick(0); tick(1);
    chk("fs_after_frame", fs_cnt, 2);
    chk("fs_now", 32'(bus.frame_start), 1);
    chk("wrap_h", 32'(bus.h_cont), 0);
    tick(0);
    chk("fs_one_cycle", 32'(bus.frame_start), 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
